bfp2fixed: RTL and testbench

- Converts the block-floating-point (mantissa + per-sample exponent) stream used inside the FFT datapath back to plain two's-complement fixed point.
- Sits at the FFT output and is the inverse of the fixed-to-BFP input converter.
- Performs a per-sample exponent-driven shift, symmetric rounding and symmetric saturation in a 3-stage pipeline.
- Tracks per-block saturation events, framed by block_sync_i.

---
 rtl/bfp2fixed.sv | 162 ++++++++++++++++
 tb/tb_bfp2fixed.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp2fixed.sv
// Block-floating-point (mantissa + per-sample exponent) to two's-complement fixed point, 3-stage pipeline.
// Define BFP2FIXED_SATCNT_EN to build the per-block saturation counter (sat_cnt_o / sat_cnt_val_o).
module bfp2fixed #(
    parameter int MAN_WIDTH = 16,
    parameter int EXP_WIDTH = 6,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_PTPOS = 14,
    parameter int CNT_WIDTH = 12
) (
    input  logic                        clk_sys,
    input  logic                        rst_sys_n,
    input  logic                        block_sync_i,
    input  logic                        data_val_i,
    input  logic signed [MAN_WIDTH-1:0] data_real_i,
    input  logic signed [MAN_WIDTH-1:0] data_imag_i,
    input  logic signed [EXP_WIDTH-1:0] data_exp_i,
    output logic                        block_sync_o,
    output logic                        data_val_o,
    output logic signed [OUT_WIDTH-1:0] data_real_o,
    output logic signed [OUT_WIDTH-1:0] data_imag_o,
    output logic                        sat_o,
    output logic [CNT_WIDTH-1:0]        sat_cnt_o,
    output logic                        sat_cnt_val_o
);

    localparam int SHW    = EXP_WIDTH + 2;
    localparam int SH_OFS = OUT_PTPOS - (MAN_WIDTH - 1);

    localparam logic signed [MAN_WIDTH-1:0] MAN_MIN     = {1'b1, {(MAN_WIDTH-1){1'b0}}};
    localparam logic signed [MAN_WIDTH-1:0] MAN_MIN_SYM = {1'b1, {(MAN_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [SHW-1:0]       SH_CLAMP    = SHW'(OUT_WIDTH);
    localparam logic [SHW-1:0]              MAN_LIM     = SHW'(MAN_WIDTH);
    localparam logic signed [31:0]          OUT_MAX     = (32'sd1 <<< (OUT_WIDTH-1)) - 32'sd1;
    localparam logic signed [31:0]          OUT_NEG     = -OUT_MAX;

    function automatic logic signed [MAN_WIDTH-1:0] presat(input logic signed [MAN_WIDTH-1:0] m);
        presat = (m == MAN_MIN) ? MAN_MIN_SYM : m;
    endfunction

    // Positive shifts clamp at OUT_WIDTH (any nonzero input clips later); negative shifts
    // round half away from zero, and shifting past the whole mantissa yields 0.
    function automatic logic signed [31:0] shift_round(input logic signed [MAN_WIDTH-1:0] m,
                                                       input logic signed [SHW-1:0]       sh);
        logic signed [31:0] ext;
        logic signed [31:0] bias;
        logic [SHW-1:0]     mag;
        ext         = {{(32-MAN_WIDTH){m[MAN_WIDTH-1]}}, m};
        bias        = '0;
        mag         = '0;
        shift_round = '0;
        if (!sh[SHW-1]) begin
            mag         = (sh > SH_CLAMP) ? SH_CLAMP : sh;
            shift_round = ext <<< mag;
        end else begin
            mag = -sh;
            if (mag <= MAN_LIM) begin
                bias        = (32'sd1 <<< (mag - SHW'(1))) - $signed({31'd0, m[MAN_WIDTH-1]});
                shift_round = (ext + bias) >>> mag;
            end
        end
    endfunction

    // MSB of the result flags a clip.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [31:0] x);
        if (x > OUT_MAX)      saturate = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        else if (x < OUT_NEG) saturate = {1'b1, OUT_NEG[OUT_WIDTH-1:0]};
        else                  saturate = {1'b0, x[OUT_WIDTH-1:0]};
    endfunction

    logic                        val_p0_q, sync_p0_q;
    logic signed [MAN_WIDTH-1:0] re_p0_q, im_p0_q;
    logic signed [SHW-1:0]       sh_p0_q;
    logic signed [SHW-1:0]       sh_p0_d;

    logic                        val_p1_q, sync_p1_q;
    logic signed [31:0]          re_p1_q, im_p1_q;

    logic                        val_p2_q, sync_p2_q, sat_p2_q;
    logic signed [OUT_WIDTH-1:0] re_p2_q, im_p2_q;
    logic [OUT_WIDTH:0]          re_sat_d, im_sat_d;
    logic                        sat_p2_d;

    assign sh_p0_d  = {{2{data_exp_i[EXP_WIDTH-1]}}, data_exp_i} + SHW'(SH_OFS);
    assign re_sat_d = saturate(re_p1_q);
    assign im_sat_d = saturate(im_p1_q);
    assign sat_p2_d = (re_sat_d[OUT_WIDTH] | im_sat_d[OUT_WIDTH]) & val_p1_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            val_p0_q  <= 1'b0;
            sync_p0_q <= 1'b0;
            re_p0_q   <= '0;
            im_p0_q   <= '0;
            sh_p0_q   <= '0;
            val_p1_q  <= 1'b0;
            sync_p1_q <= 1'b0;
            re_p1_q   <= '0;
            im_p1_q   <= '0;
            val_p2_q  <= 1'b0;
            sync_p2_q <= 1'b0;
            sat_p2_q  <= 1'b0;
            re_p2_q   <= '0;
            im_p2_q   <= '0;
        end else begin
            // stage 1: capture, symmetric pre-saturation, shift amount
            val_p0_q  <= data_val_i;
            sync_p0_q <= block_sync_i & data_val_i;
            re_p0_q   <= presat(data_real_i);
            im_p0_q   <= presat(data_imag_i);
            sh_p0_q   <= sh_p0_d;
            // stage 2: exponent shift with rounding
            val_p1_q  <= val_p0_q;
            sync_p1_q <= sync_p0_q;
            re_p1_q   <= shift_round(re_p0_q, sh_p0_q);
            im_p1_q   <= shift_round(im_p0_q, sh_p0_q);
            // stage 3: symmetric saturation
            val_p2_q  <= val_p1_q;
            sync_p2_q <= sync_p1_q;
            sat_p2_q  <= sat_p2_d;
            re_p2_q   <= $signed(re_sat_d[OUT_WIDTH-1:0]);
            im_p2_q   <= $signed(im_sat_d[OUT_WIDTH-1:0]);
        end
    end

    assign block_sync_o = sync_p2_q;
    assign data_val_o   = val_p2_q;
    assign data_real_o  = re_p2_q;
    assign data_imag_o  = im_p2_q;
    assign sat_o        = sat_p2_q;

`ifdef BFP2FIXED_SATCNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, rep_q;
    logic                 rep_val_q, seen_q;

    // Updated from the stage-3 inputs so the report strobe lines up with block_sync_o.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt_q     <= '0;
            rep_q     <= '0;
            rep_val_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            rep_val_q <= 1'b0;
            if (val_p1_q && sync_p1_q) begin
                rep_q     <= seen_q ? cnt_q : '0;
                rep_val_q <= 1'b1;
                seen_q    <= 1'b1;
                cnt_q     <= sat_p2_d ? CNT_WIDTH'(1) : '0;
            end else if (sat_p2_d && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign sat_cnt_o     = rep_q;
    assign sat_cnt_val_o = rep_val_q;
`else
    assign sat_cnt_o     = '0;
    assign sat_cnt_val_o = 1'b0;
`endif

endmodule

// File: tb/tb_bfp2fixed.sv
// Self-checking bench for bfp2fixed: directed test-plan vectors, block counter, reset and random stream.
module tb_bfp2fixed;

    localparam int MAN_W  = 16;
    localparam int EXP_W  = 6;
    localparam int OUT_W  = 16;
    localparam int OUT_PT = 14;
    localparam int CNT_W  = 12;
    localparam int OMAX   = 32767;
    localparam int CMAX   = 4095;
`ifdef BFP2FIXED_SATCNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic                    clk_sys = 1'b0;
    logic                    rst_sys_n = 1'b0;
    logic                    block_sync_i = 1'b0;
    logic                    data_val_i = 1'b0;
    logic signed [MAN_W-1:0] data_real_i = '0;
    logic signed [MAN_W-1:0] data_imag_i = '0;
    logic signed [EXP_W-1:0] data_exp_i = '0;
    logic                    block_sync_o;
    logic                    data_val_o;
    logic signed [OUT_W-1:0] data_real_o;
    logic signed [OUT_W-1:0] data_imag_o;
    logic                    sat_o;
    logic [CNT_W-1:0]        sat_cnt_o;
    logic                    sat_cnt_val_o;

    int n_tests = 0;
    int n_fail  = 0;

    bfp2fixed #(
        .MAN_WIDTH(MAN_W), .EXP_WIDTH(EXP_W), .OUT_WIDTH(OUT_W),
        .OUT_PTPOS(OUT_PT), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .block_sync_i(block_sync_i), .data_val_i(data_val_i),
        .data_real_i(data_real_i), .data_imag_i(data_imag_i), .data_exp_i(data_exp_i),
        .block_sync_o(block_sync_o), .data_val_o(data_val_o),
        .data_real_o(data_real_o), .data_imag_o(data_imag_o),
        .sat_o(sat_o), .sat_cnt_o(sat_cnt_o), .sat_cnt_val_o(sat_cnt_val_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference: value = man/2^(MAN_W-1) * 2^exp expressed with OUT_PT fraction bits,
    // rounded half away from zero, clipped symmetrically.
    function automatic void ref_conv(input int man, input int ex, output int res, output bit sat);
        longint m, v, mag, q;
        int s;
        m = man;
        if (m == -(64'sd1 <<< (MAN_W-1))) m = m + 1;
        s = ex + OUT_PT - (MAN_W - 1);
        if (s >= 0) begin
            v = m * (64'sd1 <<< s);
        end else begin
            mag = (m < 0) ? -m : m;
            q = (mag + (64'sd1 <<< (-s - 1))) / (64'sd1 <<< (-s));
            v = (m < 0) ? -q : q;
        end
        sat = 1'b0;
        if (v > OMAX) begin
            res = OMAX; sat = 1'b1;
        end else if (v < -OMAX) begin
            res = -OMAX; sat = 1'b1;
        end else begin
            res = int'(v);
        end
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input bit v, input bit sy, input int re, input int im, input int ex);
        data_val_i   = v;
        block_sync_i = sy;
        data_real_i  = MAN_W'(re);
        data_imag_i  = MAN_W'(im);
        data_exp_i   = EXP_W'(ex);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        #2 rst_sys_n = 1'b0;
        step();
        step();
        #3 rst_sys_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({data_val_o, block_sync_o, sat_o, sat_cnt_val_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {data_val_o, block_sync_o, sat_o, sat_cnt_val_o});
        end
        n_tests++;
        if ({data_real_o, data_imag_o} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d/%0d expected 0/0", data_real_o, data_imag_o);
        end
        n_tests++;
        if (sat_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", sat_cnt_o);
        end
        step();
        #3 rst_sys_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        int man[12] = '{16384, 16383, -16383, 16381, 16384, -20000, 0, -32768, 32767, 1, 3, 6};
        int imv[12] = '{-16384, -16383, 16383, -16381, -16384, 20000, 0, 32767, -32767, -1, -3, -5};
        int ex[12]  = '{1, 0, 0, 0, 2, 3, 31, 1, -20, 31, -1, 0};
        int ere[12] = '{16384, 8192, -8192, 8191, 32767, -32767, 0, -32767, 0, 32767, 1, 3};
        int eim[12] = '{-16384, -8192, 8192, -8191, -32767, 32767, 0, 32767, 0, -32767, -1, -3};
        bit esat[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        int k;
        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(1, 0, man[i], imv[i], ex[i]);
            else        drive(0, 0, 0, 0, 0);
            step();
            if (i >= 2) begin
                k = i - 2;
                n_tests++;
                if (data_val_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dir_val[%0d]: got %b expected 1", k, data_val_o);
                end
                n_tests++;
                if (int'(data_real_o) !== ere[k]) begin
                    n_fail++;
                    $display("FAIL dir_real[%0d]: got %0d expected %0d", k, data_real_o, ere[k]);
                end
                n_tests++;
                if (int'(data_imag_o) !== eim[k]) begin
                    n_fail++;
                    $display("FAIL dir_imag[%0d]: got %0d expected %0d", k, data_imag_o, eim[k]);
                end
                n_tests++;
                if (sat_o !== esat[k]) begin
                    n_fail++;
                    $display("FAIL dir_sat[%0d]: got %b expected %b", k, sat_o, esat[k]);
                end
            end
        end
        step();
        n_tests++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_drain_val: got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_block_counter();
        int k;
        bit sy, st;
        int ecnt;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                sy = (i == 0) || (i == 8);
                if (i == 2 || i == 4 || i == 6) drive(1, 0, 16384, 0, 2);
                else                            drive(1, sy, 1000 + i, -i, 0);
            end else begin
                drive(0, 0, 0, 0, 0);
            end
            step();
            if (i >= 2) begin
                k = i - 2;
                sy   = (k == 0) || (k == 8);
                st   = FEAT && sy;
                ecnt = (FEAT && k >= 8) ? 3 : 0;
                n_tests++;
                if (block_sync_o !== sy) begin
                    n_fail++;
                    $display("FAIL blk_sync[%0d]: got %b expected %b", k, block_sync_o, sy);
                end
                n_tests++;
                if (sat_o !== (k == 2 || k == 4 || k == 6)) begin
                    n_fail++;
                    $display("FAIL blk_sat[%0d]: got %b expected %b", k, sat_o, (k == 2 || k == 4 || k == 6));
                end
                n_tests++;
                if (sat_cnt_val_o !== st) begin
                    n_fail++;
                    $display("FAIL blk_strobe[%0d]: got %b expected %b", k, sat_cnt_val_o, st);
                end
                n_tests++;
                if (int'(sat_cnt_o) !== ecnt) begin
                    n_fail++;
                    $display("FAIL blk_cnt[%0d]: got %0d expected %0d", k, sat_cnt_o, ecnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        drive(1, 0, 16384, -16384, 1);
        step();
        step();
        step();
        n_tests++;
        if (data_val_o !== 1'b1 || int'(data_real_o) !== 16384) begin
            n_fail++;
            $display("FAIL mid_pre: got val=%b real=%0d expected val=1 real=16384", data_val_o, data_real_o);
        end
        #2 rst_sys_n = 1'b0;
        #1;
        n_tests++;
        if ({data_val_o, block_sync_o, sat_o, sat_cnt_val_o, data_real_o, data_imag_o, sat_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got val=%b real=%0d imag=%0d cnt=%0d expected all 0",
                     data_val_o, data_real_o, data_imag_o, sat_cnt_o);
        end
        drive(0, 0, 0, 0, 0);
        step();
        #3 rst_sys_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (data_val_o !== 1'b0 || sat_cnt_o !== '0) begin
                n_fail++;
                $display("FAIL mid_post[%0d]: got val=%b cnt=%0d expected 0/0", i, data_val_o, sat_cnt_o);
            end
        end
    endtask

    task automatic test_sync_no_val();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 16384, 16384, 5);
            step();
            n_tests++;
            if (block_sync_o !== 1'b0 || data_val_o !== 1'b0 || sat_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sync_noval[%0d]: got sync=%b val=%b sat=%b expected 0/0/0",
                         i, block_sync_o, data_val_o, sat_o);
            end
        end
        drive(0, 0, 0, 0, 0);
        step();
        step();
    endtask

    // Counter holds at all-ones; a saturating sync sample restarts it at 1.
    task automatic test_cnt_hold();
        localparam int NS = 4105;
        int k;
        bit sy, st;
        do_reset();
        for (int i = 0; i < NS + 2; i++) begin
            if (i == 0)            drive(1, 1, 100, 100, 1);
            else if (i < 4101)     drive(1, 0, 16384, 0, 2);
            else if (i == 4101)    drive(1, 1, 16384, 0, 2);
            else if (i == 4102)    drive(1, 0, 50, 50, 1);
            else if (i == 4103)    drive(1, 1, 50, 50, 1);
            else                   drive(0, 0, 0, 0, 0);
            step();
            if (i >= 2) begin
                k  = i - 2;
                sy = (k == 0) || (k == 4101) || (k == 4103);
                st = FEAT && sy;
                n_tests++;
                if (sat_cnt_val_o !== st) begin
                    n_fail++;
                    $display("FAIL hold_strobe[%0d]: got %b expected %b", k, sat_cnt_val_o, st);
                end
                if (k == 4101) begin
                    n_tests++;
                    if (int'(sat_cnt_o) !== (FEAT ? CMAX : 0)) begin
                        n_fail++;
                        $display("FAIL hold_cnt_max: got %0d expected %0d", sat_cnt_o, FEAT ? CMAX : 0);
                    end
                end
                if (k == 4103) begin
                    n_tests++;
                    if (int'(sat_cnt_o) !== (FEAT ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL hold_cnt_restart: got %0d expected %0d", sat_cnt_o, FEAT ? 1 : 0);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        bit e_val[N], e_sync[N], e_sat[N];
        int e_re[N], e_im[N];
        int rre, rim, rex, k, m_cnt, m_rep;
        bit v, sy, s1, s2, m_seen, strobe;
        logic signed [MAN_W-1:0] t16;
        logic signed [EXP_W-1:0] t6;
        do_reset();
        m_cnt = 0; m_rep = 0; m_seen = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) begin
                v  = ($urandom_range(0, 7) != 0);
                sy = ($urandom_range(0, 15) == 0);
                t16 = MAN_W'($urandom); rre = t16;
                t16 = MAN_W'($urandom); rim = t16;
                case ($urandom_range(0, 5))
                    0: rre = -32768;
                    1: rim = 0;
                    2: begin rre = $urandom_range(0, 15); rim = -rre; end
                    default: ;
                endcase
                if ($urandom_range(0, 1) == 0) rex = $urandom_range(0, 21) - 18;
                else begin t6 = EXP_W'($urandom); rex = t6; end
                drive(v, sy, rre, rim, rex);
                ref_conv(rre, rex, e_re[i], s1);
                ref_conv(rim, rex, e_im[i], s2);
                e_val[i]  = v;
                e_sync[i] = v && sy;
                e_sat[i]  = v && (s1 || s2);
            end else begin
                drive(0, 0, 0, 0, 0);
            end
            step();
            if (i >= 2) begin
                k = i - 2;
                n_tests++;
                if ({data_val_o, block_sync_o, sat_o} !== {e_val[k], e_sync[k], e_sat[k]}) begin
                    n_fail++;
                    $display("FAIL rnd_ctrl[%0d]: got val/sync/sat=%b%b%b expected %b%b%b", k,
                             data_val_o, block_sync_o, sat_o, e_val[k], e_sync[k], e_sat[k]);
                end
                if (e_val[k]) begin
                    n_tests++;
                    if (int'(data_real_o) !== e_re[k] || int'(data_imag_o) !== e_im[k]) begin
                        n_fail++;
                        $display("FAIL rnd_data[%0d]: got %0d/%0d expected %0d/%0d", k,
                                 data_real_o, data_imag_o, e_re[k], e_im[k]);
                    end
                end
                strobe = 1'b0;
                if (e_val[k] && e_sync[k]) begin
                    strobe = 1'b1;
                    m_rep  = m_seen ? m_cnt : 0;
                    m_seen = 1'b1;
                    m_cnt  = e_sat[k] ? 1 : 0;
                end else if (e_sat[k] && m_cnt < CMAX) begin
                    m_cnt++;
                end
                n_tests++;
                if (sat_cnt_val_o !== (FEAT && strobe) || int'(sat_cnt_o) !== (FEAT ? m_rep : 0)) begin
                    n_fail++;
                    $display("FAIL rnd_cnt[%0d]: got strobe=%b cnt=%0d expected strobe=%b cnt=%0d", k,
                             sat_cnt_val_o, sat_cnt_o, FEAT && strobe, FEAT ? m_rep : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_block_counter();
        test_reset_mid_flight();
        test_sync_no_val();
        test_cnt_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
